// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the pipelined MIPS core. Holds the program
// counter, presents the word index to a combinational instruction memory and
// captures the returned instruction plus PC+4 into the IF/ID register.
// Redirects (branch / jump / jump-register) resolved in ID take priority over
// a hazard stall. A misaligned redirect target parks the stage in HALT until
// reset.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, adds o_fetch_cnt / o_stall_cnt performance counters.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   i_stall             hold PC and IF/ID
//   i_pc_src            00 seq, 01 branch, 10 jump, 11 jr
//   i_id_pc_plus4       PC+4 of the instruction in ID
//   i_branch_imm        signed branch word offset
//   i_jump_index        26-bit jump target field
//   i_jr_target         rs value for jr
//   o_imem_addr         word index {2'b00, pc[31:2]}
//   i_imem_rd           instruction read at o_imem_addr
//   o_if_id_instr       IF/ID instruction
//   o_if_id_pc_plus4    IF/ID PC+4
//   o_if_id_valid       IF/ID holds a real instruction
//   o_pc                current PC (byte address)
//   o_halted            fetch halted on misaligned target
//   o_fetch_cnt         (FETCH_PERF_CNT_EN) sequential fetch count
//   o_stall_cnt         (FETCH_PERF_CNT_EN) stalled RUN cycle count
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall,
    input  logic [1:0]  i_pc_src,
    input  logic [31:0] i_id_pc_plus4,
    input  logic [15:0] i_branch_imm,
    input  logic [25:0] i_jump_index,
    input  logic [31:0] i_jr_target,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rd,
    output logic [31:0] o_if_id_instr,
    output logic [31:0] o_if_id_pc_plus4,
    output logic        o_if_id_valid,
    output logic [31:0] o_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_stall_cnt,
`endif
    output logic        o_halted
);

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic [31:0] seq_target;
    logic [31:0] redirect_target;
    logic        redirect;

    assign seq_target = pc_q + 32'd4;
    assign redirect   = (i_pc_src != 2'b00);

    always_comb begin
        redirect_target = seq_target;
        case (i_pc_src)
            2'b01:   redirect_target = i_id_pc_plus4 +
                                       {{14{i_branch_imm[15]}}, i_branch_imm, 2'b00};
            2'b10:   redirect_target = {i_id_pc_plus4[31:28], i_jump_index, 2'b00};
            2'b11:   redirect_target = i_jr_target;
            default: redirect_target = seq_target;
        endcase
    end

    // Next-state / IF/ID update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        case (state_q)
            BOOT: begin
                // One settle cycle after reset; inputs are ignored.
                state_d = RUN;
            end
            RUN: begin
                if (redirect) begin
                    // The fetch in flight is on the wrong path: squash it.
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    if (redirect_target[1:0] != 2'b00) begin
                        state_d = HALT;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else if (!i_stall) begin
                    pc_d    = seq_target;
                    instr_d = i_imem_rd;
                    pc4_d   = seq_target;
                    valid_d = 1'b1;
                end
            end
            HALT: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        run_no_redirect;

    assign run_no_redirect = (state_q == RUN) && !redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (run_no_redirect && !i_stall) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (run_no_redirect && i_stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign o_fetch_cnt = fetch_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
`endif

    assign o_imem_addr      = {2'b00, pc_q[31:2]};
    assign o_if_id_instr    = instr_q;
    assign o_if_id_pc_plus4 = pc4_q;
    assign o_if_id_valid    = valid_q;
    assign o_pc             = pc_q;
    assign o_halted         = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        i_stall;
    logic [1:0]  i_pc_src;
    logic [31:0] i_id_pc_plus4;
    logic [15:0] i_branch_imm;
    logic [25:0] i_jump_index;
    logic [31:0] i_jr_target;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_rd;
    logic [31:0] o_if_id_instr;
    logic [31:0] o_if_id_pc_plus4;
    logic        o_if_id_valid;
    logic [31:0] o_pc;
    logic        o_halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] o_fetch_cnt;
    logic [31:0] o_stall_cnt;
`endif

    int checks;
    int errors;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic [31:0] imem [0:63];

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_stall          (i_stall),
        .i_pc_src         (i_pc_src),
        .i_id_pc_plus4    (i_id_pc_plus4),
        .i_branch_imm     (i_branch_imm),
        .i_jump_index     (i_jump_index),
        .i_jr_target      (i_jr_target),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rd        (i_imem_rd),
        .o_if_id_instr    (o_if_id_instr),
        .o_if_id_pc_plus4 (o_if_id_pc_plus4),
        .o_if_id_valid    (o_if_id_valid),
        .o_pc             (o_pc),
`ifdef FETCH_PERF_CNT_EN
        .o_fetch_cnt      (o_fetch_cnt),
        .o_stall_cnt      (o_stall_cnt),
`endif
        .o_halted         (o_halted)
    );

    // Combinational instruction memory, 64 words, aliased by low index bits.
    assign i_imem_rd = imem[o_imem_addr[5:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_stall       = 1'b0;
        i_pc_src      = 2'b00;
        i_id_pc_plus4 = 32'h0;
        i_branch_imm  = 16'h0;
        i_jump_index  = 26'h0;
        i_jr_target   = 32'h0;
    endtask

    // Reset then release; consumes the BOOT edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", o_pc, 32'h0); end
        checks++; if (o_if_id_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", o_if_id_instr, NOP); end
        checks++; if (o_if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h expected %h", o_if_id_pc_plus4, 32'h0); end
        checks++; if (o_if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_if_id_valid); end
        checks++; if (o_halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", o_halted); end
        // Release; the following edge is BOOT. Drive a stall and a redirect to show they are ignored.
        rst_n    = 1'b1;
        i_stall  = 1'b1;
        i_pc_src = 2'b10;
        i_jump_index = 26'h123;
        tick();
        clear_inputs();
        checks++; if (o_imem_addr !== 32'h0) begin errors++; $display("FAIL boot_imem_addr: got %h expected %h", o_imem_addr, 32'h0); end
        checks++; if (o_if_id_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b expected 0", o_if_id_valid); end
        $display("reset: pc=%h valid=%b", o_pc, o_if_id_valid);
    endtask

    task automatic test_sequential();
        tick();
        checks++; if (o_if_id_instr !== 32'h02328020) begin errors++; $display("FAIL seq0_instr: got %h expected %h", o_if_id_instr, 32'h02328020); end
        checks++; if (o_if_id_pc_plus4 !== 32'h4) begin errors++; $display("FAIL seq0_pc4: got %h expected %h", o_if_id_pc_plus4, 32'h4); end
        checks++; if (o_if_id_valid !== 1'b1) begin errors++; $display("FAIL seq0_valid: got %b expected 1", o_if_id_valid); end
        checks++; if (o_pc !== 32'h4) begin errors++; $display("FAIL seq0_pc: got %h expected %h", o_pc, 32'h4); end
        $display("seq fetch: instr=%h pc=%h", o_if_id_instr, o_pc);
        tick();
        checks++; if (o_if_id_instr !== 32'h8C080004) begin errors++; $display("FAIL seq1_instr: got %h expected %h", o_if_id_instr, 32'h8C080004); end
        checks++; if (o_pc !== 32'h8) begin errors++; $display("FAIL seq1_pc: got %h expected %h", o_pc, 32'h8); end
        checks++; if (o_imem_addr !== 32'h2) begin errors++; $display("FAIL seq1_imem_addr: got %h expected %h", o_imem_addr, 32'h2); end
        $display("seq fetch: instr=%h pc=%h", o_if_id_instr, o_pc);
    endtask

    task automatic test_stall();
        i_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (o_pc !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected %h", c, o_pc, 32'h8); end
            checks++; if (o_if_id_instr !== 32'h8C080004) begin errors++; $display("FAIL stall_instr[%0d]: got %h expected %h", c, o_if_id_instr, 32'h8C080004); end
            checks++; if (o_if_id_pc_plus4 !== 32'h8) begin errors++; $display("FAIL stall_pc4[%0d]: got %h expected %h", c, o_if_id_pc_plus4, 32'h8); end
            checks++; if (o_if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", c, o_if_id_valid); end
            $display("stall cycle %0d: pc=%h", c, o_pc);
        end
        i_stall = 1'b0;
        tick();
        checks++; if (o_if_id_instr !== 32'hA000_0002) begin errors++; $display("FAIL unstall_instr: got %h expected %h", o_if_id_instr, 32'hA000_0002); end
        checks++; if (o_pc !== 32'hC) begin errors++; $display("FAIL unstall_pc: got %h expected %h", o_pc, 32'hC); end
        checks++; if (o_if_id_pc_plus4 !== 32'hC) begin errors++; $display("FAIL unstall_pc4: got %h expected %h", o_if_id_pc_plus4, 32'hC); end
        $display("resume: instr=%h pc=%h", o_if_id_instr, o_pc);
    endtask

    task automatic test_branch();
        i_pc_src      = 2'b01;
        i_id_pc_plus4 = 32'h10;
        i_branch_imm  = 16'hFFFC;
        tick();
        clear_inputs();
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL br_pc: got %h expected %h", o_pc, 32'h0); end
        checks++; if (o_if_id_valid !== 1'b0) begin errors++; $display("FAIL br_valid: got %b expected 0", o_if_id_valid); end
        checks++; if (o_if_id_instr !== NOP) begin errors++; $display("FAIL br_instr: got %h expected %h", o_if_id_instr, NOP); end
        $display("branch: pc=%h valid=%b", o_pc, o_if_id_valid);
        tick();
        checks++; if (o_if_id_instr !== 32'h02328020) begin errors++; $display("FAIL br_fetch_instr: got %h expected %h", o_if_id_instr, 32'h02328020); end
        checks++; if (o_if_id_valid !== 1'b1) begin errors++; $display("FAIL br_fetch_valid: got %b expected 1", o_if_id_valid); end
        checks++; if (o_pc !== 32'h4) begin errors++; $display("FAIL br_fetch_pc: got %h expected %h", o_pc, 32'h4); end
        $display("post-branch fetch: instr=%h pc=%h", o_if_id_instr, o_pc);
    endtask

    task automatic test_jump_with_stall();
        i_stall       = 1'b1;
        i_pc_src      = 2'b10;
        i_jump_index  = 26'h40;
        i_id_pc_plus4 = 32'h1000_0008;
        tick();
        clear_inputs();
        checks++; if (o_pc !== 32'h1000_0100) begin errors++; $display("FAIL jmp_pc: got %h expected %h", o_pc, 32'h1000_0100); end
        checks++; if (o_if_id_valid !== 1'b0) begin errors++; $display("FAIL jmp_valid: got %b expected 0", o_if_id_valid); end
        checks++; if (o_if_id_instr !== NOP) begin errors++; $display("FAIL jmp_instr: got %h expected %h", o_if_id_instr, NOP); end
        $display("jump+stall: pc=%h valid=%b", o_pc, o_if_id_valid);
        tick();
        // 0x1000_0100 -> word index low 6 bits 0 -> imem[0]
        checks++; if (o_if_id_instr !== 32'h02328020) begin errors++; $display("FAIL jmp_fetch_instr: got %h expected %h", o_if_id_instr, 32'h02328020); end
        checks++; if (o_if_id_pc_plus4 !== 32'h1000_0104) begin errors++; $display("FAIL jmp_fetch_pc4: got %h expected %h", o_if_id_pc_plus4, 32'h1000_0104); end
        $display("post-jump fetch: instr=%h pc=%h", o_if_id_instr, o_pc);
    endtask

    task automatic test_jr_halt();
        i_pc_src    = 2'b11;
        i_jr_target = 32'h22;
        tick();
        clear_inputs();
        checks++; if (o_halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b expected 1", o_halted); end
        checks++; if (o_pc !== 32'h1000_0104) begin errors++; $display("FAIL halt_pc: got %h expected %h", o_pc, 32'h1000_0104); end
        checks++; if (o_if_id_valid !== 1'b0) begin errors++; $display("FAIL halt_valid: got %b expected 0", o_if_id_valid); end
        checks++; if (o_if_id_instr !== NOP) begin errors++; $display("FAIL halt_instr: got %h expected %h", o_if_id_instr, NOP); end
        $display("jr misaligned: halted=%b pc=%h", o_halted, o_pc);
        // Redirects and sequential attempts must not move a halted PC.
        for (int c = 0; c < 10; c++) begin
            i_pc_src      = (c % 2 == 0) ? 2'b01 : 2'b00;
            i_id_pc_plus4 = 32'h40;
            tick();
            checks++; if (o_pc !== 32'h1000_0104) begin errors++; $display("FAIL halt_frozen_pc[%0d]: got %h expected %h", c, o_pc, 32'h1000_0104); end
        end
        clear_inputs();
        checks++; if (o_halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b expected 1", o_halted); end
        checks++; if (o_if_id_valid !== 1'b0) begin errors++; $display("FAIL halt_sticky_valid: got %b expected 0", o_if_id_valid); end
        // Asynchronous reset out of HALT, mid-cycle.
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (o_halted !== 1'b0) begin errors++; $display("FAIL halt_reset_flag: got %b expected 0", o_halted); end
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL halt_reset_pc: got %h expected %h", o_pc, 32'h0); end
        $display("reset from halt: halted=%b pc=%h", o_halted, o_pc);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (o_if_id_instr !== 32'h02328020) begin errors++; $display("FAIL halt_restart_instr: got %h expected %h", o_if_id_instr, 32'h02328020); end
    endtask

    task automatic test_wrap();
        // pc is 4 here; jr to aligned top word then fetch sequentially.
        i_pc_src    = 2'b11;
        i_jr_target = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        checks++; if (o_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_jr_pc: got %h expected %h", o_pc, 32'hFFFF_FFFC); end
        checks++; if (o_halted !== 1'b0) begin errors++; $display("FAIL wrap_no_halt: got %b expected 0", o_halted); end
        tick();
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected %h", o_pc, 32'h0); end
        checks++; if (o_if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h expected %h", o_if_id_pc_plus4, 32'h0); end
        checks++; if (o_if_id_instr !== 32'hA000_003F) begin errors++; $display("FAIL wrap_instr: got %h expected %h", o_if_id_instr, 32'hA000_003F); end
        $display("wrap: pc=%h instr=%h", o_pc, o_if_id_instr);
    endtask

    task automatic test_back_to_back();
        i_pc_src      = 2'b01;
        i_id_pc_plus4 = 32'h20;
        i_branch_imm  = 16'h0004;
        tick();
        checks++; if (o_pc !== 32'h30) begin errors++; $display("FAIL b2b_br_pc: got %h expected %h", o_pc, 32'h30); end
        i_pc_src      = 2'b10;
        i_id_pc_plus4 = 32'hA000_0000;
        i_jump_index  = 26'h3;
        tick();
        clear_inputs();
        checks++; if (o_pc !== 32'hA000_000C) begin errors++; $display("FAIL b2b_j_pc: got %h expected %h", o_pc, 32'hA000_000C); end
        checks++; if (o_if_id_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid: got %b expected 0", o_if_id_valid); end
        tick();
        checks++; if (o_if_id_instr !== 32'hA000_0003) begin errors++; $display("FAIL b2b_instr: got %h expected %h", o_if_id_instr, 32'hA000_0003); end
        checks++; if (o_pc !== 32'hA000_0010) begin errors++; $display("FAIL b2b_pc: got %h expected %h", o_pc, 32'hA000_0010); end
        $display("back-to-back: instr=%h pc=%h", o_if_id_instr, o_pc);
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_counters();
        do_reset();
        checks++; if (o_fetch_cnt !== 32'd0) begin errors++; $display("FAIL perf_boot_fetch: got %0d expected 0", o_fetch_cnt); end
        for (int c = 0; c < 5; c++) tick();
        i_stall = 1'b1;
        tick();
        tick();
        // Stall alongside a redirect counts as neither.
        i_pc_src      = 2'b01;
        i_id_pc_plus4 = 32'h0;
        tick();
        clear_inputs();
        checks++; if (o_fetch_cnt !== 32'd5) begin errors++; $display("FAIL perf_fetch: got %0d expected 5", o_fetch_cnt); end
        checks++; if (o_stall_cnt !== 32'd2) begin errors++; $display("FAIL perf_stall: got %0d expected 2", o_stall_cnt); end
        $display("perf: fetch=%0d stall=%0d", o_fetch_cnt, o_stall_cnt);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (o_fetch_cnt !== 32'd0) begin errors++; $display("FAIL perf_reset_fetch: got %0d expected 0", o_fetch_cnt); end
        checks++; if (o_stall_cnt !== 32'd0) begin errors++; $display("FAIL perf_reset_stall: got %0d expected 0", o_stall_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) imem[i] = 32'hA000_0000 + i;
        imem[0] = 32'h02328020;
        imem[1] = 32'h8C080004;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump_with_stall();
        test_jr_halt();
        test_wrap();
        test_back_to_back();
`ifdef FETCH_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
